rf_wb_arbiter: RTL and testbench
================================

Name: rf_wb_arbiter

Overview:
- Shares the register file's single synchronous write port among NUM_SRC writeback sources, e.g. the ALU/load path and a multi-cycle unit.
- Each source has a valid/ready handshake. One grant per cycle, chosen round-robin.
- The winning write is registered and driven onto the RF write port one cycle later.
- Writes to x0 are accepted and dropped, so they never reach the register file.

Parameters:
- NUM_SRC, 2: number of writeback requesters; legal range 2..8.

Ports:
- i_clk  input  1  global clock
- i_rst  input  1  synchronous active-high reset
- i_src_valid  input  NUM_SRC  per-source write request; bit k belongs to source k
- i_src_waddr  input  5*NUM_SRC  destination register; source k occupies bits [5k+4:5k]
- i_src_wdata  input  32*NUM_SRC  write data; source k occupies bits [32k+31:32k]
- o_src_ready  output  NUM_SRC  one-hot (or zero) grant; transfer when valid & ready
- o_rd_wen  output  1  to RF write enable
- o_rd_waddr  output  5  to RF write address
- o_rd_wdata  output  32  to RF write data

Behaviour:
- State:
  - Round-robin pointer ptr, width clog2(NUM_SRC), range 0..NUM_SRC-1.
  - Output stage registers wen_q, waddr_q, wdata_q, which drive o_rd_* directly.
- Reset (i_rst high at posedge):
  - ptr=0, wen_q=0, waddr_q=0, wdata_q=0.
  - While i_rst is high, o_src_ready=0 combinationally.
  - A write held in the output stage when reset is asserted is discarded; o_rd_wen=0 the cycle after.
- Grant (combinational):
  - Scan sources ptr, ptr+1, ..., wrapping modulo NUM_SRC.
  - The first source with valid=1 gets ready=1; all others get ready=0.
  - With no valid source, ready is all zeros.
  - Ready never depends on the ready output of any source.
- The output stage never stalls: the RF always accepts, so at most one transfer occurs per cycle and throughput is 1 write/cycle.
- On a transfer from source g at a posedge:
  - waddr_q=src_waddr[g], wdata_q=src_wdata[g].
  - wen_q=1 if waddr≠0, else wen_q=0 (x0 write is consumed silently).
  - ptr = (g+1) mod NUM_SRC. The pointer advances even for x0 writes.
- With no transfer: wen_q=0, waddr_q/wdata_q hold their previous values, ptr holds.
- Latency: request accepted in cycle N → o_rd_wen high in cycle N+1 → RF content updated at the end of cycle N+1.
- Sources hold valid/waddr/wdata stable until they see ready. A source may drop valid before grant; the arbiter keeps no request memory.
- Same-address writes from two sources: applied in grant order in consecutive cycles, so the later-granted data wins in the RF.
- Starvation bound: a continuously valid source is granted within NUM_SRC cycles.
- Wrap-around: the grant after source NUM_SRC-1 resumes scanning at source 0.
- Implemented for any NUM_SRC in range, not hard-coded to 2.

Test Plan:
- Reset then idle:
  - Stimulus: i_rst=1 for 2 cycles with src_valid=2'b11, then release with src_valid=0.
  - Required: o_src_ready=0 during reset; o_rd_wen=0, waddr=0, wdata=0; ptr=0.
- Single source:
  - Stimulus: src0 valid, waddr=5, wdata=0xDEADBEEF, for 1 cycle.
  - Required: ready0=1 in the same cycle; next cycle o_rd_wen=1, o_rd_waddr=5, o_rd_wdata=0xDEADBEEF; the cycle after that o_rd_wen=0.
- Contention, NUM_SRC=2:
  - Stimulus: both sources valid for 4 cycles; src0 (x1, 0x11), src1 (x2, 0x22), each re-presenting after every grant.
  - Required: grants alternate 0,1,0,1; o_rd_waddr sequence 1,2,1,2, one cycle delayed.
- x0 drop:
  - Stimulus: src1 valid, waddr=0, wdata=0xFFFFFFFF.
  - Required: ready1=1; next cycle o_rd_wen=0; ptr becomes 0; a following src0 write to x3 proceeds normally.
- Reset mid-operation:
  - Stimulus: src0 accepted (x7, 0x77) at posedge N; i_rst=1 at posedge N+1.
  - Required: o_rd_wen=0 after N+1 and x7 never written; the bench RF reads x7=0.
- Integration with the register file, bypass disabled:
  - Stimulus: src0 and src1 both write x4 (0xA then 0xB) in back-to-back grants.
  - Required: x4 reads 0xA after the first write cycle and 0xB after the second.

Source files
------------

// File: rtl/rf_wb_arbiter.sv
`default_nettype none
// ============================================================================
// rf_wb_arbiter : round-robin arbiter sharing the single RF write port among
//                 NUM_SRC writeback sources; x0 writes are accepted and dropped.
// Revision      : 1.0
// ============================================================================
module rf_wb_arbiter #(
  parameter int NUM_SRC = 2
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  input  logic [NUM_SRC-1:0]      i_src_valid,
  input  logic [5*NUM_SRC-1:0]    i_src_waddr,
  input  logic [32*NUM_SRC-1:0]   i_src_wdata,
  output logic [NUM_SRC-1:0]      o_src_ready,
  output logic                    o_rd_wen,
  output logic [4:0]              o_rd_waddr,
  output logic [31:0]             o_rd_wdata
);

  localparam int PTR_W = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;
  localparam logic [PTR_W-1:0] C_LAST_SRC = PTR_W'(NUM_SRC - 1);

  logic [PTR_W-1:0]   ptr_q, ptr_d;
  logic               wen_q, wen_d;
  logic [4:0]         waddr_q, waddr_d;
  logic [31:0]        wdata_q, wdata_d;

  logic [NUM_SRC-1:0] grant;
  logic               grant_any;
  logic [PTR_W-1:0]   grant_idx;
  logic [4:0]         sel_waddr;
  logic [31:0]        sel_wdata;

  // First valid source at or after ptr, wrapping; reset masks every grant.
  always_comb begin : grant_scan
    int idx;
    grant     = '0;
    grant_any = 1'b0;
    grant_idx = '0;
    idx       = 0;
    for (int i = 0; i < NUM_SRC; i++) begin
      idx = (int'(ptr_q) + i) % NUM_SRC;
      if (!grant_any && i_src_valid[idx]) begin
        grant_any  = 1'b1;
        grant[idx] = 1'b1;
        grant_idx  = PTR_W'(idx);
      end
    end
    if (i_rst) begin
      grant     = '0;
      grant_any = 1'b0;
    end
  end

  assign sel_waddr = i_src_waddr[5*int'(grant_idx) +: 5];
  assign sel_wdata = i_src_wdata[32*int'(grant_idx) +: 32];

  always_comb begin : next_state
    ptr_d   = ptr_q;
    wen_d   = 1'b0;
    waddr_d = waddr_q;
    wdata_d = wdata_q;
    if (grant_any) begin
      waddr_d = sel_waddr;
      wdata_d = sel_wdata;
      wen_d   = (sel_waddr != 5'd0);
      ptr_d   = (grant_idx == C_LAST_SRC) ? '0 : grant_idx + PTR_W'(1);
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      ptr_q   <= '0;
      wen_q   <= 1'b0;
      waddr_q <= 5'd0;
      wdata_q <= 32'd0;
    end else begin
      ptr_q   <= ptr_d;
      wen_q   <= wen_d;
      waddr_q <= waddr_d;
      wdata_q <= wdata_d;
    end
  end

  assign o_src_ready = grant;
  assign o_rd_wen    = wen_q;
  assign o_rd_waddr  = waddr_q;
  assign o_rd_wdata  = wdata_q;

endmodule
`default_nettype wire

// File: tb/tb_rf_wb_arbiter.sv
`default_nettype none
// ============================================================================
// tb_rf_wb_arbiter : directed + randomized bench for rf_wb_arbiter against a
//                    queue-free behavioural model and a bench register file.
// Revision         : 1.0
// ============================================================================
module tb_rf_wb_arbiter;

  localparam int N = 2;

  logic              clk = 1'b0;
  logic              rst;
  logic [N-1:0]      src_valid;
  logic [5*N-1:0]    src_waddr;
  logic [32*N-1:0]   src_wdata;
  logic [N-1:0]      src_ready;
  logic              rd_wen;
  logic [4:0]        rd_waddr;
  logic [31:0]       rd_wdata;

  int n_cmp = 0;
  int n_mis = 0;

  // model state
  int          m_ptr;
  logic        m_wen;
  logic [4:0]  m_waddr;
  logic [31:0] m_wdata;
  logic [31:0] rf_exp [32];
  logic [31:0] rf_dut [32] = '{default: 32'd0};
  int          wait_cnt [N];
  int          g_last;

  always #5 clk = ~clk;

  rf_wb_arbiter #(.NUM_SRC(N)) u_dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_src_valid (src_valid),
    .i_src_waddr (src_waddr),
    .i_src_wdata (src_wdata),
    .o_src_ready (src_ready),
    .o_rd_wen    (rd_wen),
    .o_rd_waddr  (rd_waddr),
    .o_rd_wdata  (rd_wdata)
  );

  // Bench RF: the RF is held in reset alongside the arbiter, so no write lands then.
  always @(posedge clk) begin
    if (!rst && rd_wen && rd_waddr != 5'd0) rf_dut[rd_waddr] <= rd_wdata;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic set_src(input int k, input logic v, input logic [4:0] a, input logic [31:0] d);
    src_valid[k]        = v;
    src_waddr[5*k +: 5]   = a;
    src_wdata[32*k +: 32] = d;
  endtask

  function automatic int pick();
    if (rst) return -1;
    for (int i = 0; i < N; i++) begin
      if (src_valid[(m_ptr + i) % N]) return (m_ptr + i) % N;
    end
    return -1;
  endfunction

  // One clock cycle: inputs already applied after the previous negedge.
  task automatic cycle();
    int g;
    int probe;
    logic [N-1:0] exp_ready;
    #1;
    g = pick();
    exp_ready = '0;
    if (g >= 0) exp_ready[g] = 1'b1;
    chk("ready", 32'(src_ready), 32'(exp_ready));
    if (g >= 0) begin
      chk("starve", 32'(wait_cnt[g] <= N - 1), 32'd1);
    end
    for (int k = 0; k < N; k++) begin
      if (rst || k == g || !src_valid[k]) wait_cnt[k] = 0;
      else wait_cnt[k]++;
    end
    @(posedge clk);
    if (!rst && m_wen && m_waddr != 5'd0) rf_exp[m_waddr] = m_wdata;
    if (rst) begin
      m_ptr = 0; m_wen = 1'b0; m_waddr = 5'd0; m_wdata = 32'd0;
    end else if (g >= 0) begin
      m_waddr = src_waddr[5*g +: 5];
      m_wdata = src_wdata[32*g +: 32];
      m_wen   = (m_waddr != 5'd0);
      m_ptr   = (g + 1) % N;
    end else begin
      m_wen = 1'b0;
    end
    g_last = g;
    #1;
    chk("wen",   32'(rd_wen),   32'(m_wen));
    chk("waddr", 32'(rd_waddr), 32'(m_waddr));
    chk("wdata", rd_wdata,      m_wdata);
    probe = $urandom_range(0, 31);
    chk("rf", rf_dut[probe], rf_exp[probe]);
    @(negedge clk);
  endtask

  initial begin
    for (int r = 0; r < 32; r++) rf_exp[r] = 32'd0;
    for (int k = 0; k < N; k++) wait_cnt[k] = 0;
    m_ptr = 0; m_wen = 1'b0; m_waddr = 5'd0; m_wdata = 32'd0; g_last = -1;
    src_valid = '0; src_waddr = '0; src_wdata = '0;
    rst = 1'b1;
    @(negedge clk);

    // reset with requests present, then idle
    set_src(0, 1'b1, 5'd1, 32'h1); set_src(1, 1'b1, 5'd2, 32'h2);
    cycle(); cycle();
    chk("rst_wen", 32'(rd_wen), 32'd0);
    chk("rst_waddr", 32'(rd_waddr), 32'd0);
    chk("rst_wdata", rd_wdata, 32'd0);
    rst = 1'b0; src_valid = '0;
    cycle();

    // single source
    set_src(0, 1'b1, 5'd5, 32'hDEADBEEF);
    cycle();
    chk("single_wen", 32'(rd_wen), 32'd1);
    chk("single_data", rd_wdata, 32'hDEADBEEF);
    src_valid = '0;
    cycle();
    chk("single_wen_off", 32'(rd_wen), 32'd0);
    cycle();
    chk("single_rf", rf_dut[5], 32'hDEADBEEF);

    // contention from ptr=0
    rst = 1'b1; cycle(); rst = 1'b0;
    set_src(0, 1'b1, 5'd1, 32'h11); set_src(1, 1'b1, 5'd2, 32'h22);
    for (int i = 0; i < 4; i++) begin
      cycle();
      chk("alt_grant", 32'(g_last), 32'(i % 2));
      chk("alt_waddr", 32'(rd_waddr), 32'((i % 2) + 1));
    end
    src_valid = '0;

    // x0 drop, then ptr back at 0 so src0 wins
    set_src(1, 1'b1, 5'd0, 32'hFFFFFFFF);
    cycle();
    chk("x0_wen", 32'(rd_wen), 32'd0);
    set_src(0, 1'b1, 5'd3, 32'h33); set_src(1, 1'b1, 5'd9, 32'h99);
    cycle();
    chk("x0_next", 32'(rd_waddr), 32'd3);
    src_valid = '0;
    cycle(); cycle();
    chk("x3_rf", rf_dut[3], 32'h33);
    chk("x0_rf", rf_dut[0], 32'd0);

    // reset mid-operation drops the staged x7 write
    set_src(0, 1'b1, 5'd7, 32'h77);
    cycle();
    src_valid = '0; rst = 1'b1;
    cycle();
    chk("midrst_wen", 32'(rd_wen), 32'd0);
    rst = 1'b0;
    cycle(); cycle();
    chk("x7_rf", rf_dut[7], 32'd0);

    // same-address writes, later grant wins
    set_src(0, 1'b1, 5'd4, 32'hA); set_src(1, 1'b1, 5'd4, 32'hB);
    cycle();
    set_src(0, 1'b0, 5'd0, 32'd0);
    cycle();
    src_valid = '0;
    chk("x4_first", rf_dut[4], 32'hA);
    cycle();
    chk("x4_second", rf_dut[4], 32'hB);

    // randomized traffic
    for (int c = 0; c < 400; c++) begin
      rst = ($urandom_range(0, 63) == 0);
      for (int k = 0; k < N; k++) begin
        if (!src_valid[k] || g_last == k) begin
          if ($urandom_range(0, 9) < 6)
            set_src(k, 1'b1, 5'($urandom_range(0, 31)), $urandom);
          else
            set_src(k, 1'b0, 5'd0, 32'd0);
        end else if ($urandom_range(0, 9) == 0) begin
          set_src(k, 1'b0, 5'd0, 32'd0);
        end
      end
      cycle();
    end
    rst = 1'b0; src_valid = '0;
    cycle(); cycle();
    for (int r = 0; r < 32; r++) chk("rf_final", rf_dut[r], rf_exp[r]);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
`default_nettype wire
